vending_controller: RTL and testbench

//   Sequencing controller for the vending machine datapath.
//   - Accumulates coin credit and validates item selections against a fixed price table.
//   - Drives a req/ack handshake to the product dispenser.
//   - Returns change one coin at a time over a valid/ready handshake.
//   - Sits between the coin/keypad front end and the dispenser/change-hopper mechanics.
//

---
 rtl/vend_pkg.sv | 30 +++
 rtl/vend_change_sel.sv | 20 ++
 rtl/vending_controller.sv | 163 ++++++++++++++++
 tb/tb_vending_controller.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// vend_pkg: coin encoding, FSM states and price table
// shared by the vending_controller slice.
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_BAD     = 2'b00,
    COIN_NICKEL  = 2'b01,
    COIN_DIME    = 2'b10,
    COIN_QUARTER = 2'b11
  } coin_e;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DISPENSE,
    CHANGE
  } state_e;

  localparam int PRICE [4] = '{25, 50, 65, 100};

  function automatic logic [7:0] COIN_VALUE(coin_e c);
    case (c)
      COIN_NICKEL:  return 8'd5;
      COIN_DIME:    return 8'd10;
      COIN_QUARTER: return 8'd25;
      default:      return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_change_sel.sv
// vend_change_sel: greedy largest-coin-first change selector
// driven from the current credit.
module vend_change_sel
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] credit,
  output coin_e               coin
);

  always_comb begin
    coin = COIN_NICKEL;
    if (credit >= CREDIT_W'(25))
      coin = COIN_QUARTER;
    else if (credit >= CREDIT_W'(10))
      coin = COIN_DIME;
  end

endmodule

// File: rtl/vending_controller.sv
// vending_controller: coin credit, price check, dispense and change FSM.
// Optional idle auto-refund is built when VEND_TIMEOUT_EN is defined.
module vending_controller
  import vend_pkg::*;
#(
  parameter int MAX_CREDIT  = 150,
  parameter int CREDIT_W    = 8,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  output logic                coin_acc,
  output logic                coin_rej,
  input  logic                sel_valid,
  input  logic [1:0]          sel_item,
  output logic                sel_nack,
  input  logic                cancel,
  output logic                disp_req,
  output logic [1:0]          disp_item,
  input  logic                disp_ack,
  output logic                chg_valid,
  output logic [1:0]          chg_coin,
  input  logic                chg_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                timeout
);

  localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W+1)'(MAX_CREDIT);

  state_e              state, state_n;
  logic [CREDIT_W-1:0] credit_q, credit_n;
  logic [1:0]          item_q, item_n;
  logic                acc_q, acc_n;
  logic                rej_q, rej_n;
  logic                nack_q, nack_n;
  logic                tmo_q, tmo_n;
  logic [CREDIT_W-1:0] coin_v, chg_v, price;
  logic [CREDIT_W:0]   sum;
  logic                coin_ok;
  coin_e               chg_sel;

  vend_change_sel #(
    .CREDIT_W(CREDIT_W)
  ) u_chg (
    .credit(credit_q),
    .coin  (chg_sel)
  );

`ifdef VEND_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt, cnt_n;

  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_n;
  end
`endif

  always_comb begin
    state_n  = state;
    credit_n = credit_q;
    item_n   = item_q;
    acc_n    = 1'b0;
    rej_n    = 1'b0;
    nack_n   = 1'b0;
    tmo_n    = 1'b0;
    coin_v   = CREDIT_W'(COIN_VALUE(coin_e'(coin_type)));
    chg_v    = CREDIT_W'(COIN_VALUE(chg_sel));
    price    = CREDIT_W'(PRICE[sel_item]);
    sum      = {1'b0, credit_q} + {1'b0, coin_v};
    coin_ok  = (coin_type != 2'b00) && (sum <= MAX_C);

    unique case (state)
      IDLE, COLLECT: begin
        if (state == COLLECT && cancel) begin
          state_n = CHANGE;
          rej_n   = coin_valid;
          nack_n  = sel_valid;
        end else if (coin_valid) begin
          nack_n = sel_valid;
          if (coin_ok) begin
            credit_n = sum[CREDIT_W-1:0];
            acc_n    = 1'b1;
            state_n  = COLLECT;
          end else begin
            rej_n = 1'b1;
          end
        end else if (sel_valid) begin
          if (state == COLLECT && credit_q >= price) begin
            credit_n = credit_q - price;
            item_n   = sel_item;
            state_n  = DISPENSE;
          end else begin
            nack_n = 1'b1;
          end
        end
      end
      DISPENSE: begin
        rej_n = coin_valid;
        if (disp_ack)
          state_n = (credit_q != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        rej_n = coin_valid;
        if (chg_ready) begin
          credit_n = credit_q - chg_v;
          if (credit_n == '0) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

`ifdef VEND_TIMEOUT_EN
    // idle COLLECT cycles only; any accepted coin restarts the count
    cnt_n = '0;
    if (state == COLLECT && state_n == COLLECT && !acc_n) begin
      if (cnt == CNT_MAX) begin
        tmo_n   = 1'b1;
        state_n = CHANGE;
      end else begin
        cnt_n = cnt + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      credit_q <= '0;
      item_q   <= '0;
      acc_q    <= 1'b0;
      rej_q    <= 1'b0;
      nack_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state    <= state_n;
      credit_q <= credit_n;
      item_q   <= item_n;
      acc_q    <= acc_n;
      rej_q    <= rej_n;
      nack_q   <= nack_n;
      tmo_q    <= tmo_n;
    end
  end

  assign coin_acc  = acc_q;
  assign coin_rej  = rej_q;
  assign sel_nack  = nack_q;
  assign timeout   = tmo_q;
  assign credit    = credit_q;
  assign disp_req  = (state == DISPENSE);
  assign disp_item = disp_req ? item_q : 2'b00;
  assign chg_valid = (state == CHANGE);
  assign chg_coin  = chg_valid ? chg_sel : 2'b00;
  assign busy      = disp_req | chg_valid;

endmodule

// File: tb/tb_vending_controller.sv
// tb_vending_controller: vector table plus hand sequences,
// expected outputs queued at drive time and checked after each edge.
module tb_vending_controller;

  localparam int TMO = 20;
  localparam logic [1:0] N = 2'b01;
  localparam logic [1:0] D = 2'b10;
  localparam logic [1:0] Q = 2'b11;

  typedef struct packed {
    logic       rst;
    logic       cv;
    logic [1:0] ct;
    logic       sv;
    logic [1:0] si;
    logic       cn;
    logic       ack;
    logic       rdy;
  } in_t;

  typedef struct packed {
    logic       acc;
    logic       rej;
    logic       nack;
    logic       dreq;
    logic [1:0] di;
    logic       chv;
    logic [1:0] cc;
    logic [7:0] cr;
    logic       busy;
    logic       tmo;
  } out_t;

  typedef struct {
    string tag;
    in_t   in;
    out_t  exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       coin_acc;
  logic       coin_rej;
  logic       sel_valid;
  logic [1:0] sel_item;
  logic       sel_nack;
  logic       cancel;
  logic       disp_req;
  logic [1:0] disp_item;
  logic       disp_ack;
  logic       chg_valid;
  logic [1:0] chg_coin;
  logic       chg_ready;
  logic [7:0] credit;
  logic       busy;
  logic       timeout;

  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl[$];
  out_t exp_q[$];

  always #5 clk = ~clk;

  vending_controller #(
    .MAX_CREDIT (150),
    .CREDIT_W   (8),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .coin_valid(coin_valid),
    .coin_type (coin_type),
    .coin_acc  (coin_acc),
    .coin_rej  (coin_rej),
    .sel_valid (sel_valid),
    .sel_item  (sel_item),
    .sel_nack  (sel_nack),
    .cancel    (cancel),
    .disp_req  (disp_req),
    .disp_item (disp_item),
    .disp_ack  (disp_ack),
    .chg_valid (chg_valid),
    .chg_coin  (chg_coin),
    .chg_ready (chg_ready),
    .credit    (credit),
    .busy      (busy),
    .timeout   (timeout)
  );

  function automatic in_t i_nop();
    in_t r = '0;
    return r;
  endfunction

  function automatic in_t i_rst();
    in_t r = '0;
    r.rst = 1'b1;
    return r;
  endfunction

  function automatic in_t i_coin(logic [1:0] t);
    in_t r = '0;
    r.cv = 1'b1;
    r.ct = t;
    return r;
  endfunction

  function automatic in_t i_sel(logic [1:0] it);
    in_t r = '0;
    r.sv = 1'b1;
    r.si = it;
    return r;
  endfunction

  function automatic in_t i_cancel();
    in_t r = '0;
    r.cn = 1'b1;
    return r;
  endfunction

  function automatic in_t i_ack();
    in_t r = '0;
    r.ack = 1'b1;
    return r;
  endfunction

  function automatic in_t i_rdy();
    in_t r = '0;
    r.rdy = 1'b1;
    return r;
  endfunction

  function automatic out_t o(bit acc, bit rej, bit nack, bit dreq,
                             logic [1:0] di, bit chv, logic [1:0] cc,
                             int cr, bit bsy);
    out_t r;
    r.acc  = acc;
    r.rej  = rej;
    r.nack = nack;
    r.dreq = dreq;
    r.di   = di;
    r.chv  = chv;
    r.cc   = cc;
    r.cr   = 8'(cr);
    r.busy = bsy;
    r.tmo  = 1'b0;
    return r;
  endfunction

  function automatic void add(string tag, in_t i, out_t e);
    vec_t v;
    v.tag = tag;
    v.in  = i;
    v.exp = e;
    tbl.push_back(v);
  endfunction

  task automatic apply(input string tag, input in_t i, input out_t e);
    out_t got, want;
    rst_n      = ~i.rst;
    coin_valid = i.cv;
    coin_type  = i.ct;
    sel_valid  = i.sv;
    sel_item   = i.si;
    cancel     = i.cn;
    disp_ack   = i.ack;
    chg_ready  = i.rdy;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = {coin_acc, coin_rej, sel_nack, disp_req, disp_item,
           chg_valid, chg_coin, credit, busy, timeout};
    want = exp_q.pop_front();
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %p want %p", tag, got, want);
    end
  endtask

  initial begin
    out_t e;

    // 1: two quarters, item1, exact credit, no change
    add("rst",      i_rst(),       o(0,0,0,0,0,0,0,  0,0));
    add("t1 q1",    i_coin(Q),     o(1,0,0,0,0,0,0, 25,0));
    add("t1 q2",    i_coin(Q),     o(1,0,0,0,0,0,0, 50,0));
    add("t1 sel1",  i_sel(1),      o(0,0,0,1,1,0,0,  0,1));
    add("t1 hold",  i_nop(),       o(0,0,0,1,1,0,0,  0,1));
    add("t1 ack",   i_ack(),       o(0,0,0,0,0,0,0,  0,0));
    add("t1 idle",  i_nop(),       o(0,0,0,0,0,0,0,  0,0));
    // 2: 75 cents, item2 (65), one dime back
    add("t2 q1",    i_coin(Q),     o(1,0,0,0,0,0,0, 25,0));
    add("t2 q2",    i_coin(Q),     o(1,0,0,0,0,0,0, 50,0));
    add("t2 q3",    i_coin(Q),     o(1,0,0,0,0,0,0, 75,0));
    add("t2 sel2",  i_sel(2),      o(0,0,0,1,2,0,0, 10,1));
    add("t2 ack",   i_ack(),       o(0,0,0,0,0,1,D, 10,1));
    add("t2 chg",   i_rdy(),       o(0,0,0,0,0,0,0,  0,0));
    // 3: short credit nack, then cancel refund
    add("t3 dime",  i_coin(D),     o(1,0,0,0,0,0,0, 10,0));
    add("t3 nack",  i_sel(0),      o(0,0,1,0,0,0,0, 10,0));
    add("t3 cncl",  i_cancel(),    o(0,0,0,0,0,1,D, 10,1));
    add("t3 chg",   i_rdy(),       o(0,0,0,0,0,0,0,  0,0));
    // 4: fill to MAX_CREDIT, overflow and illegal coins
    for (int k = 1; k <= 6; k++)
      add("t4 fill", i_coin(Q),    o(1,0,0,0,0,0,0, 25*k,0));
    add("t4 ovf",   i_coin(N),     o(0,1,0,0,0,0,0,150,0));
    add("t4 prio",  i_cancel() | i_coin(D) | i_sel(0),
                                   o(0,1,1,0,0,1,Q,150,1));
    for (int k = 5; k >= 1; k--)
      add("t4 rfnd", i_rdy(),      o(0,0,0,0,0,1,Q, 25*k,1));
    add("t4 done",  i_rdy(),       o(0,0,0,0,0,0,0,  0,0));
    add("t4 bad",   i_coin(2'b00), o(0,1,0,0,0,0,0,  0,0));
    add("t4 idsel", i_sel(0),      o(0,0,1,0,0,0,0,  0,0));
    // 5: coin in DISPENSE, stalled hopper
    add("t5 q1",    i_coin(Q),     o(1,0,0,0,0,0,0, 25,0));
    add("t5 q2",    i_coin(Q),     o(1,0,0,0,0,0,0, 50,0));
    add("t5 q3",    i_coin(Q),     o(1,0,0,0,0,0,0, 75,0));
    add("t5 sel0",  i_sel(0),      o(0,0,0,1,0,0,0, 50,1));
    add("t5 dcoin", i_coin(Q),     o(0,1,0,1,0,0,0, 50,1));
    add("t5 ign",   i_sel(3) | i_cancel(),
                                   o(0,0,0,1,0,0,0, 50,1));
    add("t5 ack",   i_ack(),       o(0,0,0,0,0,1,Q, 50,1));
    for (int k = 0; k < 5; k++)
      add("t5 stall", i_nop(),     o(0,0,0,0,0,1,Q, 50,1));
    add("t5 chg1",  i_rdy(),       o(0,0,0,0,0,1,Q, 25,1));
    add("t5 chg2",  i_rdy(),       o(0,0,0,0,0,0,0,  0,0));
    // coin beats select; 15 refunds as dime then nickel
    add("p dime",   i_coin(D),     o(1,0,0,0,0,0,0, 10,0));
    add("p cs",     i_coin(N) | i_sel(0),
                                   o(1,0,1,0,0,0,0, 15,0));
    add("p cncl",   i_cancel(),    o(0,0,0,0,0,1,D, 15,1));
    add("p dchg",   i_rdy(),       o(0,0,0,0,0,1,N,  5,1));
    add("p nchg",   i_rdy(),       o(0,0,0,0,0,0,0,  0,0));
    // 6: reset in CHANGE and in DISPENSE
    add("r q",      i_coin(Q),     o(1,0,0,0,0,0,0, 25,0));
    add("r cncl",   i_cancel(),    o(0,0,0,0,0,1,Q, 25,1));
    add("r rst",    i_rst() | i_rdy(),
                                   o(0,0,0,0,0,0,0,  0,0));
    add("r after",  i_nop(),       o(0,0,0,0,0,0,0,  0,0));
    add("r q2",     i_coin(Q),     o(1,0,0,0,0,0,0, 25,0));
    add("r sel",    i_sel(0),      o(0,0,0,1,0,0,0,  0,1));
    add("r rst2",   i_rst(),       o(0,0,0,0,0,0,0,  0,0));
    add("r ack",    i_ack(),       o(0,0,0,0,0,0,0,  0,0));

    foreach (tbl[k])
      apply(tbl[k].tag, tbl[k].in, tbl[k].exp);

    // idle COLLECT: auto-refund only when the timeout is built
    apply("to q", i_coin(Q), o(1,0,0,0,0,0,0, 25,0));
    for (int k = 1; k < TMO; k++)
      apply("to wait", i_nop(), o(0,0,0,0,0,0,0, 25,0));
`ifdef VEND_TIMEOUT_EN
    e = o(0,0,0,0,0,1,Q, 25,1);
    e.tmo = 1'b1;
    apply("to fire", i_nop(), e);
    apply("to post", i_nop(), o(0,0,0,0,0,1,Q, 25,1));
`else
    for (int k = 0; k < 10; k++)
      apply("to hold", i_nop(), o(0,0,0,0,0,0,0, 25,0));
    apply("to cncl", i_cancel(), o(0,0,0,0,0,1,Q, 25,1));
`endif
    apply("to rfnd", i_rdy(), o(0,0,0,0,0,0,0, 0,0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
